// File: rtl/demux_pkg.sv
`default_nettype none
// ============================================================================
// Module   : demux_pkg
// Brief    : Shared types and constants for the demux8_deser serial-to-parallel block
// Revision : 1.0  initial release
// ============================================================================
package demux_pkg;

    localparam int WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        PAR  = 2'd1,
        WAIT = 2'd2
    } demux_state_t;

endpackage : demux_pkg
`default_nettype wire

// File: rtl/demux8_deser_if.sv
`default_nettype none
// ============================================================================
// Module   : demux8_deser_if
// Brief    : Serial-in / word-out handshake bundle for demux8_deser
// Revision : 1.0  initial release
// ============================================================================
interface demux8_deser_if
    import demux_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
);
    localparam int c_SEL_W = $clog2(WIDTH);

    logic               flush;
    logic               in_valid;
    logic               in_ready;
    logic               in_bit;
    logic [c_SEL_W-1:0] sel;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out;
    logic               out_perr;

    modport master (
        output flush, in_valid, in_bit, out_ready,
        input  in_ready, sel, out_valid, out, out_perr
    );

    modport slave (
        input  flush, in_valid, in_bit, out_ready,
        output in_ready, sel, out_valid, out, out_perr
    );

endinterface : demux8_deser_if
`default_nettype wire

// File: rtl/demux8_outreg.sv
`default_nettype none
// ============================================================================
// Module   : demux8_outreg
// Brief    : One-word valid/ready holding register with a load port
// Revision : 1.0  initial release
// ============================================================================
module demux8_outreg #(
    parameter int WIDTH = 8
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             i_load,
    input  wire logic [WIDTH-1:0] i_data,
    input  wire logic             i_perr,
    input  wire logic             i_ready,
    output logic                  o_valid,
    output logic [WIDTH-1:0]      o_data,
    output logic                  o_perr
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic             r_perr;

    // A load on the same edge as a consumer take keeps valid high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_perr  <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_perr  <= i_perr;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_perr  = r_perr;

endmodule : demux8_outreg
`default_nettype wire

// File: rtl/demux8_deser.sv
`default_nettype none
// ============================================================================
// Module   : demux8_deser
// Brief    : Bit-serial to WIDTH-lane word demultiplexer with valid/ready output.
//            Define DEMUX_PARITY_EN to append an even-parity beat to every word.
// Revision : 1.0  initial release
// ============================================================================
module demux8_deser
    import demux_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    demux8_deser_if.slave bus
);

    localparam int c_SEL_W = $clog2(WIDTH);

    demux_state_t       r_state;
    demux_state_t       w_state_nxt;
    logic [c_SEL_W-1:0] r_sel;
    logic [WIDTH-1:0]   r_fill;
`ifdef DEMUX_PARITY_EN
    logic               r_par;
`endif

    logic               w_in_ready;
    logic               w_accept;
    logic               w_last_lane;
    logic               w_out_free;
    logic               w_done;
    logic               w_load;
    logic [WIDTH-1:0]   w_word;
    logic               w_perr;
    logic               w_out_valid;
    logic [WIDTH-1:0]   w_out_data;
    logic               w_out_perr;

    assign w_last_lane = (r_sel == c_SEL_W'(WIDTH - 1));
    assign w_accept    = bus.in_valid & w_in_ready & ~bus.flush;
    assign w_out_free  = ~w_out_valid | bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (bus.flush) begin
            w_state_nxt = FILL;
        end else begin
            case (r_state)
                FILL: begin
                    if (w_accept && w_last_lane) begin
`ifdef DEMUX_PARITY_EN
                        w_state_nxt = PAR;
`else
                        w_state_nxt = w_out_free ? FILL : WAIT;
`endif
                    end
                end
                PAR: begin
                    if (w_accept) begin
                        w_state_nxt = w_out_free ? FILL : WAIT;
                    end
                end
                WAIT: begin
                    if (bus.out_ready) begin
                        w_state_nxt = FILL;
                    end
                end
                default: w_state_nxt = FILL;
            endcase
        end
    end

    always_comb begin
        w_in_ready = (r_state != WAIT);
`ifdef DEMUX_PARITY_EN
        w_done = w_accept && (r_state == PAR);
        w_word = r_fill;
        w_perr = ^{r_fill, ((r_state == WAIT) ? r_par : bus.in_bit)};
`else
        w_done = w_accept && (r_state == FILL) && w_last_lane;
        // Completing beat bypasses the fill buffer so the word loads on its own edge.
        w_word = (r_state == WAIT) ? r_fill : {bus.in_bit, r_fill[WIDTH-2:0]};
        w_perr = 1'b0;
`endif
        w_load = ~bus.flush &
                 ((w_done & w_out_free) | ((r_state == WAIT) & bus.out_ready));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel  <= '0;
            r_fill <= '0;
`ifdef DEMUX_PARITY_EN
            r_par  <= 1'b0;
`endif
        end else if (bus.flush) begin
            r_sel <= '0;
        end else if (w_accept) begin
            if (r_state == FILL) begin
                r_fill[r_sel] <= bus.in_bit;
`ifdef DEMUX_PARITY_EN
                // Hold on the last lane while the parity beat is outstanding.
                if (!w_last_lane) begin
                    r_sel <= r_sel + 1'b1;
                end
`else
                r_sel <= w_last_lane ? '0 : r_sel + 1'b1;
`endif
            end
`ifdef DEMUX_PARITY_EN
            if (r_state == PAR) begin
                r_par <= bus.in_bit;
                r_sel <= '0;
            end
`endif
        end
    end

    demux8_outreg #(
        .WIDTH (WIDTH)
    ) u_outreg (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_load),
        .i_data  (w_word),
        .i_perr  (w_perr),
        .i_ready (bus.out_ready),
        .o_valid (w_out_valid),
        .o_data  (w_out_data),
        .o_perr  (w_out_perr)
    );

    assign bus.in_ready  = w_in_ready;
    assign bus.sel       = r_sel;
    assign bus.out_valid = w_out_valid;
    assign bus.out       = w_out_data;
    assign bus.out_perr  = w_out_perr;

endmodule : demux8_deser
`default_nettype wire

// File: tb/tb_demux8_deser.sv
`default_nettype none
// ============================================================================
// Module   : tb_demux8_deser
// Brief    : Directed and randomised scoreboard bench for demux8_deser
// Revision : 1.0  initial release
// ============================================================================
module tb_demux8_deser;
    import demux_pkg::*;

    localparam int W = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    demux8_deser_if #(.WIDTH(W)) bus ();

    demux8_deser #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct packed {
        logic [W-1:0] word;
        logic         perr;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp   = 0;
    int   n_err   = 0;
    bit   chk_sel = 1'b0;
    int   m_sel   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Output monitor and sel tracker; negedge sits between input drive and the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $error("FAIL unexpected_word: observed %0h expected none", bus.out);
                end else begin
                    mon_e = sb.pop_front();
                    chk("word", {24'd0, bus.out}, {24'd0, mon_e.word});
                    chk("perr", {31'd0, bus.out_perr}, {31'd0, mon_e.perr});
                end
            end
            if (chk_sel) begin
                chk("sel_track", {29'd0, bus.sel}, m_sel);
                if (bus.in_valid && bus.in_ready && !bus.flush) m_sel = (m_sel + 1) % W;
            end
        end
    end

    task automatic beat(input logic b);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_bit   = b;
        @(negedge clk);
        while (!bus.in_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (!bus.in_ready) begin
            n_cmp++;
            n_err++;
            $error("FAIL beat_timeout: observed in_ready=0 expected 1");
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [W-1:0] w, input logic par, input logic exp_perr);
        sb.push_back('{word: w, perr: exp_perr});
        for (int i = 0; i < W; i++) beat(w[i]);
`ifdef DEMUX_PARITY_EN
        beat(par);
`endif
    endtask

    task automatic send(input logic [W-1:0] w);
        send_word(w, ^w, 1'b0);
    endtask

    task automatic drain(input int max_cyc);
        int n = 0;
        while (sb.size() != 0 && n < max_cyc) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] rw;
        logic         bq[$];
        int           idx;
        int           cyc;
        bit           acc;
        logic [W-1:0] pat5;

        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_bit    = 1'b0;
        bus.out_ready = 1'b0;
        #12;
        chk("rst_sel",       {29'd0, bus.sel}, 0);
        chk("rst_out_valid", {31'd0, bus.out_valid}, 0);
        chk("rst_out",       {24'd0, bus.out}, 0);
        chk("rst_perr",      {31'd0, bus.out_perr}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_in_ready", {31'd0, bus.in_ready}, 1);

        // Test 1: 1,0,1,1,0,0,1,0 LSB first
        bus.out_ready = 1'b1;
        send(8'h4D);
        chk("t1_valid", {31'd0, bus.out_valid}, 1);
        chk("t1_out",   {24'd0, bus.out}, 32'h4D);
        drain(10);

        // Test 2: back-to-back with consumer stalled
        bus.out_ready = 1'b0;
        send(8'hA5);
        chk("t2_hold_valid", {31'd0, bus.out_valid}, 1);
        send(8'h3C);
        chk("t2_in_ready_low", {31'd0, bus.in_ready}, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("t2_held_out", {24'd0, bus.out}, 32'hA5);
        chk("t2_sb_pending", sb.size(), 2);
        bus.out_ready = 1'b1;
        drain(20);
        chk("t2_sb_empty", sb.size(), 0);
        @(posedge clk);
        #1;
        chk("t2_valid_clear", {31'd0, bus.out_valid}, 0);
        chk("t2_in_ready_back", {31'd0, bus.in_ready}, 1);

        // Test 3: flush after a partial word
        pat5 = 8'b0001_1011;
        for (int i = 0; i < 5; i++) beat(pat5[i]);
        chk("t3_sel5", {29'd0, bus.sel}, 5);
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        chk("t3_sel_flush", {29'd0, bus.sel}, 0);
        send(8'hFF);
        drain(10);
        chk("t3_sb_empty", sb.size(), 0);
        chk("t3_out", {24'd0, bus.out}, 32'hFF);

        // Test 4: async reset while a word is held and another is mid-fill
        bus.out_ready = 1'b0;
        send(8'h96);
        for (int i = 0; i < 4; i++) beat(1'b1);
        chk("t4_sel4", {29'd0, bus.sel}, 4);
        chk("t4_valid_pre", {31'd0, bus.out_valid}, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t4_sel", {29'd0, bus.sel}, 0);
        chk("t4_valid", {31'd0, bus.out_valid}, 0);
        chk("t4_out", {24'd0, bus.out}, 0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        chk("t4_valid_after", {31'd0, bus.out_valid}, 0);

        // Test 5: random in_valid and out_ready against the scoreboard
        chk("t5_sel_start", {29'd0, bus.sel}, 0);
        m_sel = 0;
`ifndef DEMUX_PARITY_EN
        chk_sel = 1'b1;
`endif
        for (int k = 0; k < 4; k++) begin
            rw = W'($urandom);
            sb.push_back('{word: rw, perr: 1'b0});
            for (int i = 0; i < W; i++) bq.push_back(rw[i]);
`ifdef DEMUX_PARITY_EN
            bq.push_back(^rw);
`endif
        end
        idx = 0;
        cyc = 0;
        while (idx < bq.size() && cyc < 2000) begin
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.in_bit    = bq[idx];
            bus.out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            acc = bus.in_valid && bus.in_ready;
            @(posedge clk);
            #1;
            if (acc) idx++;
            cyc++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        chk("t5_all_bits", idx, bq.size());
        drain(50);
        chk_sel = 1'b0;
        chk("t5_sb_empty", sb.size(), 0);

`ifdef DEMUX_PARITY_EN
        // Test 6: parity good then bad
        send_word(8'h01, 1'b1, 1'b0);
        chk("t6_perr_good", {31'd0, bus.out_perr}, 0);
        drain(10);
        send_word(8'h01, 1'b0, 1'b1);
        chk("t6_perr_bad", {31'd0, bus.out_perr}, 1);
        drain(10);
        chk("t6_sb_empty", sb.size(), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_demux8_deser
`default_nettype wire
